ovr_mac_scheduler: RTL and testbench

// - Sequences one shared multiply-accumulate over NUM_CLASS one-vs-all logistic-regression

---
 rtl/ovr_pkg.sv | 18 +
 rtl/ovr_mac_scheduler_if.sv | 32 +++
 rtl/ovr_mac.sv | 28 ++
 rtl/ovr_mac_scheduler.sv | 149 ++++++++++++++
 tb/tb_ovr_mac_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ovr_pkg.sv
// Shared parameters, address widths and scheduler state type for the
// one-vs-all MAC scheduler.
package ovr_pkg;

    localparam int W         = 32;
    localparam int NUM_FEAT  = 41;
    localparam int NUM_CLASS = 10;
    localparam int CW        = $clog2(NUM_CLASS);
    localparam int FW        = $clog2(NUM_FEAT);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        COMPARE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

endpackage

// File: rtl/ovr_mac_scheduler_if.sv
// Feature-stream input and result output of the scheduler, plus its state
// as a debug view.
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid && ready are both high. The source holds valid and its payload
// until that edge. The sink may change ready at any time.
interface ovr_mac_scheduler_if;
    import ovr_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_class;
    logic [W-1:0]  out_score;

    state_t        dbg_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, dbg_state
    );

endinterface

// File: rtl/ovr_mac.sv
// Shared multiply-accumulate. Products and sums keep only the low W bits,
// so the accumulator wraps modulo 2^W.
module ovr_mac
    import ovr_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc
);

    logic [W-1:0] prod;

    assign prod = a * b;

    // Accumulator: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/ovr_mac_scheduler.sv
// Buffers one feature vector. It then runs one shared MAC over every class's
// theta set and returns the argmax class together with its raw score.
module ovr_mac_scheduler
    import ovr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ovr_mac_scheduler_if.slave bus,
    output logic [CW-1:0] th_class,
    output logic [FW-1:0] th_feat,
    input  logic [W-1:0]  th_data,
    output logic          busy
);

    state_t        state;
    state_t        state_nxt;

    logic [FW-1:0] k;           // load beat index
    logic [FW-1:0] f;           // feature issue index, NUM_FEAT = drain cycle
    logic [FW-1:0] f_d;         // feature index of the theta arriving now
    logic          v_d;         // th_data holds a requested theta this cycle
    logic [CW-1:0] c;           // class being scheduled
    logic [W-1:0]  x [NUM_FEAT];

    logic [CW-1:0] best_class;
    logic [W-1:0]  best_score;

    logic          beat;
    logic          last_beat;
    logic          f_last;
    logic          c_last;
    logic          hs;
    logic [W-1:0]  mac_a;
    logic          mac_clr;
    logic [W-1:0]  acc;

    assign beat      = bus.in_valid && (state == LOAD);
    assign last_beat = beat && (bus.in_last || (k == FW'(NUM_FEAT - 1)));
    assign f_last    = (f == FW'(NUM_FEAT));
    assign c_last    = (c == CW'(NUM_CLASS - 1));
    assign hs        = (state == OUTPUT) && bus.out_ready;

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_class = best_class;
    assign bus.out_score = best_score;
    assign bus.dbg_state = state;
    assign busy          = (state != LOAD);

    assign th_class = c;
    assign th_feat  = ((state == COMPUTE) && !f_last) ? f : '0;

    // The bias slot multiplies by a constant 1, whatever beat 0 carried.
    assign mac_a   = (f_d == '0) ? W'(1) : x[f_d];
    assign mac_clr = (state == COMPARE) || (state == LOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (last_beat) state_nxt = COMPUTE;
            COMPUTE: if (f_last)    state_nxt = COMPARE;
            COMPARE: state_nxt = c_last ? OUTPUT : COMPUTE;
            OUTPUT:  if (bus.out_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Load beat counter. It restarts after every vector.
    always_ff @(posedge clk) begin
        if (rst || last_beat) begin
            k <= '0;
        end else if (beat) begin
            k <= k + 1'b1;
        end
    end

    // Feature buffer. It is cleared on reset and on result acceptance, so a short vector reads 0 in unloaded slots.
    always_ff @(posedge clk) begin
        if (rst || hs) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                x[i] <= '0;
            end
        end else if (beat) begin
            x[k] <= bus.in_data;
        end
    end

    // Issue counter: NUM_FEAT address cycles plus one drain cycle per class.
    always_ff @(posedge clk) begin
        if (rst || (state != COMPUTE) || f_last) begin
            f <= '0;
        end else begin
            f <= f + 1'b1;
        end
    end

    // Track the ROM read latency: which feature the returning theta belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_d <= 1'b0;
            f_d <= '0;
        end else begin
            v_d <= (state == COMPUTE) && !f_last;
            f_d <= f;
        end
    end

    // Class counter. It advances once per COMPARE cycle and wraps to 0 after the last class.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
        end else if (state == COMPARE) begin
            c <= c_last ? '0 : c + 1'b1;
        end
    end

    // Argmax. Class 0 always seeds it. A strict signed greater-than keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_class <= '0;
            best_score <= '0;
        end else if ((state == COMPARE) &&
                     ((c == '0) || ($signed(acc) > $signed(best_score)))) begin
            best_class <= c;
            best_score <= acc;
        end
    end

    ovr_mac u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (v_d),
        .a   (mac_a),
        .b   (th_data),
        .acc (acc)
    );

endmodule

// File: tb/tb_ovr_mac_scheduler.sv
// Directed and randomized bench for ovr_mac_scheduler, using a theta ROM model
// and a loop-based reference of the one-vs-all argmax.
module tb_ovr_mac_scheduler;
    import ovr_pkg::*;

    logic          clk;
    logic          rst;
    logic [CW-1:0] th_class;
    logic [FW-1:0] th_feat;
    logic [W-1:0]  th_data;
    logic          busy;

    ovr_mac_scheduler_if bus ();

    ovr_mac_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .th_class (th_class),
        .th_feat  (th_feat),
        .th_data  (th_data),
        .busy     (busy)
    );

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] theta [NUM_CLASS][NUM_FEAT];
    logic [W-1:0] xr [NUM_FEAT];
    logic [W-1:0] obs_class;
    logic [W-1:0] obs_score;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // theta ROM with one cycle of read latency
    always @(posedge clk) begin
        if (int'(th_class) < NUM_CLASS && int'(th_feat) < NUM_FEAT)
            th_data <= theta[int'(th_class)][int'(th_feat)];
        else
            th_data <= '0;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference: score[c] = theta0 + sum x[i]*theta[i] over loaded slots, wrap 2^W, first signed max
    task automatic model(input int n, output logic [W-1:0] bc, output logic [W-1:0] bs);
        logic [W-1:0] s;
        logic [W-1:0] p;
        bc = '0;
        bs = '0;
        for (int cc = 0; cc < NUM_CLASS; cc++) begin
            s = theta[cc][0];
            for (int i = 1; i < NUM_FEAT; i++) begin
                p = (i < n) ? xr[i] * theta[cc][i] : '0;
                s = s + p;
            end
            if (cc == 0 || $signed(s) > $signed(bs)) begin
                bc = W'(cc);
                bs = s;
            end
        end
    endtask

    // driver: n beats of xr, optional in_last on the final one, random idle gaps
    task automatic send_vec(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = xr[i];
            bus.in_last  = use_last && (i == n - 1);
            chk("in_ready_load", W'(bus.in_ready), W'(1));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // wait for the result, check latency/result/stability, then accept it
    task automatic get_result(input int n, input int hold);
        int cyc;
        logic [W-1:0] ec;
        logic [W-1:0] es;
        cyc = 0;
        do begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = $urandom;
            bus.in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end while (!bus.out_valid && cyc < 600);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("latency", W'(cyc), W'(430));
        model(n, ec, es);
        obs_class = W'(bus.out_class);
        obs_score = bus.out_score;
        chk("out_class", obs_class, ec);
        chk("out_score", obs_score, es);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", W'(bus.out_valid), W'(1));
            chk("hold_class", W'(bus.out_class), ec);
            chk("hold_score", bus.out_score, es);
            chk("hold_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        chk("hs_in_ready", W'(bus.in_ready), W'(0));
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_hs_valid", W'(bus.out_valid), W'(0));
        chk("post_hs_in_ready", W'(bus.in_ready), W'(1));
        chk("post_hs_busy", W'(busy), W'(0));
    endtask

    task automatic fill_theta(input logic [W-1:0] v);
        for (int cc = 0; cc < NUM_CLASS; cc++)
            for (int i = 0; i < NUM_FEAT; i++)
                theta[cc][i] = v;
    endtask

    initial begin
        int n;
        int cyc;
        bit seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        fill_theta('0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_out_class", W'(bus.out_class), W'(0));
        chk("rst_out_score", bus.out_score, W'(0));
        chk("rst_th_class", W'(th_class), W'(0));
        chk("rst_th_feat", W'(th_feat), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // step 1: x all zero, 41 beats with forced end, theta0[3] = 5
        for (int cc = 0; cc < NUM_CLASS; cc++) begin
            theta[cc][0] = 1;
            for (int i = 1; i < NUM_FEAT; i++) theta[cc][i] = $urandom;
        end
        theta[3][0] = 5;
        for (int i = 0; i < NUM_FEAT; i++) xr[i] = '0;
        send_vec(NUM_FEAT, 1'b0);
        get_result(NUM_FEAT, 20);
        chk("t1_class", obs_class, W'(3));
        chk("t1_score", obs_score, W'(5));

        // step 2: x = 2, thetas 1, class 7 thetas 2
        fill_theta(W'(1));
        for (int i = 1; i < NUM_FEAT; i++) theta[7][i] = 2;
        xr[0] = $urandom;
        for (int i = 1; i < NUM_FEAT; i++) xr[i] = 2;
        send_vec(NUM_FEAT, 1'b1);
        get_result(NUM_FEAT, 2);
        chk("t2_class", obs_class, W'(7));
        chk("t2_score", obs_score, W'(161));

        // step 3: all scores negative, tie at -2 between classes 4 and 6
        fill_theta('0);
        for (int cc = 0; cc < NUM_CLASS; cc++) theta[cc][0] = 32'hFFFF_FFF0 - W'(cc);
        theta[4][0] = 32'hFFFF_FFFE;
        theta[6][0] = 32'hFFFF_FFFE;
        for (int i = 0; i < NUM_FEAT; i++) xr[i] = $urandom;
        send_vec(NUM_FEAT, 1'b1);
        get_result(NUM_FEAT, 1);
        chk("t3_class", obs_class, W'(4));
        chk("t3_score", obs_score, 32'hFFFF_FFFE);

        // step 4: short vector, in_last on beat 3, stale slots must read 0
        fill_theta(W'(1));
        for (int cc = 0; cc < NUM_CLASS; cc++) theta[cc][0] = 0;
        xr[0] = $urandom;
        xr[1] = 3;
        xr[2] = 4;
        xr[3] = 0;
        send_vec(4, 1'b1);
        get_result(4, 0);
        chk("t4_class", obs_class, W'(0));
        chk("t4_score", obs_score, W'(7));

        // step 5: randomized vectors with wrapping arithmetic
        for (int t = 0; t < 3; t++) begin
            for (int cc = 0; cc < NUM_CLASS; cc++)
                for (int i = 0; i < NUM_FEAT; i++) theta[cc][i] = $urandom;
            for (int i = 0; i < NUM_FEAT; i++) xr[i] = $urandom;
            n = $urandom_range(1, NUM_FEAT);
            send_vec(n, (n < NUM_FEAT) ? 1'b1 : 1'($urandom_range(0, 1)));
            get_result(n, $urandom_range(0, 5));
        end

        // step 6: reset while class 5 is being computed
        for (int i = 0; i < NUM_FEAT; i++) xr[i] = $urandom;
        send_vec(NUM_FEAT, 1'b1);
        cyc = 0;
        while (!(th_class == CW'(5) && th_feat == FW'(20)) && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_class5", W'(cyc < 600), W'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", W'(bus.in_ready), W'(1));
        chk("midrst_out_valid", W'(bus.out_valid), W'(0));
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_out_score", bus.out_score, W'(0));
        chk("midrst_th_class", W'(th_class), W'(0));
        seen = 1'b0;
        for (int i = 0; i < 450; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", W'(seen), W'(0));
        for (int cc = 0; cc < NUM_CLASS; cc++)
            for (int i = 0; i < NUM_FEAT; i++) theta[cc][i] = W'($urandom_range(0, 1000));
        for (int i = 0; i < NUM_FEAT; i++) xr[i] = W'($urandom_range(0, 1000));
        n = $urandom_range(2, NUM_FEAT - 1);
        send_vec(n, 1'b1);
        get_result(n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
